// File: rtl/wb_target_arb_wdog.sv
// Per-target Wishbone arbiter: round-robin grant locked for the whole cyc,
// plus a watchdog that errors a strobed transfer the target never answers.
module wb_target_arb_wdog #(
    parameter int N_REQ     = 2,
    parameter int TIMEOUT   = 255,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     cyc,
    input  logic [N_REQ-1:0]     stb,
    input  logic                 tack,
    input  logic                 terr,
    output logic [N_REQ-1:0]     gnt,
    output logic                 busy,
    output logic                 stb_kill,
    output logic [N_REQ-1:0]     wd_err,
    output logic [CNT_WIDTH-1:0] wd_count
);

    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam bit WD_EN = (TIMEOUT != 0);
    localparam logic [CNT_WIDTH-1:0] TO_LAST  = WD_EN ? CNT_WIDTH'(TIMEOUT - 1) : '0;
    localparam logic [OW-1:0]        LAST_RST = OW'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    state_t                r_state, w_state_nxt;
    logic [N_REQ-1:0]      r_gnt, w_gnt_nxt, w_req;
    logic [OW-1:0]         r_owner, w_owner_nxt, r_last, w_last_nxt, w_win;
    logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt, r_wdcnt, w_wdcnt_nxt;
    logic                  r_busy, w_found, w_own_cyc, w_own_stb;
    int                    w_idx;

    assign w_req     = cyc & stb;
    assign w_own_cyc = cyc[r_owner];
    assign w_own_stb = stb[r_owner];

    // Round-robin scan starting just above the previous owner.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = (int'(r_last) + i) % N_REQ;
            if (!w_found && w_req[OW'(w_idx)]) begin
                w_found = 1'b1;
                w_win   = OW'(w_idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_wdcnt_nxt = r_wdcnt;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = BUSY;
                    w_gnt_nxt   = N_REQ'(1) << w_win;
                    w_owner_nxt = w_win;
                    w_cnt_nxt   = '0;
                end
            end
            BUSY: begin
                if (!w_own_cyc) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_last_nxt  = r_owner;
                end else if (tack || terr) begin
                    w_cnt_nxt = '0;
                end else if (w_own_stb && WD_EN && (r_cnt == TO_LAST)) begin
                    w_state_nxt = ERR;
                end else if (w_own_stb) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            ERR: begin
                if (r_wdcnt != '1) begin
                    w_wdcnt_nxt = r_wdcnt + 1'b1;
                end
                w_cnt_nxt = '0;
                if (!w_own_cyc) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_last_nxt  = r_owner;
                end else begin
                    w_state_nxt = BUSY;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_last  <= LAST_RST;
            r_cnt   <= '0;
            r_wdcnt <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wdcnt <= w_wdcnt_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    // Error strobes decode straight from registers so they carry no input paths.
    assign stb_kill = (r_state == ERR);
    assign wd_err   = stb_kill ? r_gnt : '0;
    assign gnt      = r_gnt;
    assign busy     = r_busy;
    assign wd_count = r_wdcnt;

endmodule

// File: tb/tb_wb_target_arb_wdog.sv
// Bench for wb_target_arb_wdog: two instances (watchdog on / off) driven by
// shared stimulus and compared each cycle against a transaction-level model.
module tb_wb_target_arb_wdog;

    localparam int N  = 3;
    localparam int TO = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] cyc, stb;
    logic       tack, terr;
    logic [2:0] gnt_a, wd_err_a, gnt_b, wd_err_b;
    logic       busy_a, kill_a, busy_b, kill_b;
    logic [7:0] wdc_a, wdc_b;
    logic       chk_on = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clock = ~clock;

    wb_target_arb_wdog #(.N_REQ(N), .TIMEOUT(TO), .CNT_WIDTH(8)) dut_a (
        .clock(clock), .reset(reset), .cyc(cyc), .stb(stb), .tack(tack), .terr(terr),
        .gnt(gnt_a), .busy(busy_a), .stb_kill(kill_a), .wd_err(wd_err_a), .wd_count(wdc_a));

    wb_target_arb_wdog #(.N_REQ(N), .TIMEOUT(0), .CNT_WIDTH(8)) dut_b (
        .clock(clock), .reset(reset), .cyc(cyc), .stb(stb), .tack(tack), .terr(terr),
        .gnt(gnt_b), .busy(busy_b), .stb_kill(kill_b), .wd_err(wd_err_b), .wd_count(wdc_b));

    typedef struct {
        bit busy;
        bit inerr;
        int owner;
        int last;
        int cnt;
        int wdc;
    } mst_t;

    mst_t ma, mb;

    function automatic mst_t mrst();
        mst_t s;
        s.busy = 0; s.inerr = 0; s.owner = 0; s.last = N - 1; s.cnt = 0; s.wdc = 0;
        return s;
    endfunction

    function automatic mst_t mstep(mst_t s, logic [2:0] c, logic [2:0] st, logic ack, int to);
        mst_t n;
        int   k;
        n = s;
        if (!s.busy) begin
            for (int i = 1; i <= N; i++) begin
                k = (s.last + i) % N;
                if (c[k[1:0]] && st[k[1:0]]) begin
                    n.busy = 1; n.owner = k; n.cnt = 0;
                    break;
                end
            end
        end else begin
            if (s.inerr) begin
                n.wdc   = (s.wdc == 255) ? 255 : s.wdc + 1;
                n.inerr = 0;
                n.cnt   = 0;
            end
            if (!c[s.owner[1:0]]) begin
                n.busy = 0;
                n.last = s.owner;
            end else if (!s.inerr) begin
                if (ack) n.cnt = 0;
                else if (st[s.owner[1:0]] && to != 0 && s.cnt == to - 1) n.inerr = 1;
                else if (st[s.owner[1:0]]) n.cnt = s.cnt + 1;
                else n.cnt = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            ma <= mrst();
            mb <= mrst();
        end else begin
            ma <= mstep(ma, cyc, stb, tack | terr, TO);
            mb <= mstep(mb, cyc, stb, tack | terr, 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input mst_t m, input logic [2:0] g, input logic b,
                       input logic k, input logic [2:0] we, input logic [7:0] wc);
        logic [2:0] eg;
        eg = m.busy ? 3'(1 << m.owner) : 3'b000;
        chk({tag, "_gnt"}, g, eg);
        chk({tag, "_busy"}, b, m.busy);
        chk({tag, "_stb_kill"}, k, m.inerr);
        chk({tag, "_wd_err"}, we, m.inerr ? eg : 3'b000);
        chk({tag, "_wd_count"}, wc, m.wdc);
    endtask

    always @(negedge clock) begin
        if (chk_on) begin
            cmp("A", ma, gnt_a, busy_a, kill_a, wd_err_a, wdc_a);
            cmp("B", mb, gnt_b, busy_b, kill_b, wd_err_b, wdc_b);
        end
    end

    task automatic wait_gnt(output int own);
        own = -1;
        for (int t = 0; t < 6; t++) begin
            if (gnt_a != 0) break;
            @(negedge clock);
        end
        chk("grant_wait_bound", (gnt_a != 0), 1);
        for (int i = 0; i < N; i++) if (gnt_a[i]) own = i;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not end, expected finish");
        $fatal(1);
    end

    int order[5];
    int exp_order[5] = '{0, 1, 2, 0, 1};
    int own;
    logic [2:0] keep;

    initial begin
        cyc = '0; stb = '0; tack = 0; terr = 0; reset = 1;
        chk_on = 1'b1;
        repeat (2) @(negedge clock);
        chk("reset_gnt", gnt_a, 3'b000);
        chk("reset_wd_count", wdc_a, 8'd0);
        reset = 0;
        @(negedge clock);
        cyc = 3'b101; stb = 3'b101;
        @(negedge clock);
        chk("first_grant", gnt_a, 3'b001);
        cyc = 3'b100; stb = 3'b100;
        @(negedge clock);
        chk("release_gap", gnt_a, 3'b000);
        @(negedge clock);
        chk("second_grant", gnt_a, 3'b100);
        cyc = 3'b000; stb = 3'b000;
        @(negedge clock);

        // Owner 1 strobes and the target stays silent.
        cyc = 3'b010; stb = 3'b010;
        @(negedge clock);
        chk("wd_grant", gnt_a, 3'b010);
        repeat (7) begin
            @(negedge clock);
            chk("wd_wait_no_err", wd_err_a, 3'b000);
        end
        @(negedge clock);
        chk("wd_err_hit", wd_err_a, 3'b010);
        chk("wd_kill_hit", kill_a, 1'b1);
        chk("wd_off_no_err", wd_err_b, 3'b000);
        @(negedge clock);
        chk("wd_err_one_cycle", wd_err_a, 3'b000);
        chk("wd_count_one", wdc_a, 8'd1);
        chk("wd_gnt_held", gnt_a, 3'b010);

        // tack on exactly the last allowed waiting cycle.
        repeat (7) @(negedge clock);
        tack = 1;
        @(negedge clock);
        tack = 0;
        chk("tack_wins_kill", kill_a, 1'b0);
        chk("tack_wins_count", wdc_a, 8'd1);
        repeat (3) begin
            repeat (6) @(negedge clock);
            stb = 3'b000;
            @(negedge clock);
            stb = 3'b010;
        end
        chk("gapped_beats_count", wdc_a, 8'd1);
        cyc = 3'b000; stb = 3'b000;
        @(negedge clock);
        chk("wd_release", gnt_a, 3'b000);

        // Drive into the error cycle and reset in the middle of it.
        cyc = 3'b010; stb = 3'b010;
        repeat (9) @(negedge clock);
        chk("err_before_reset", kill_a, 1'b1);
        #1 reset = 1;
        #1;
        chk("async_rst_gnt", gnt_a, 3'b000);
        chk("async_rst_wd_err", wd_err_a, 3'b000);
        chk("async_rst_kill", kill_a, 1'b0);
        chk("async_rst_wd_count", wdc_a, 8'd0);
        @(negedge clock);
        reset = 0;
        cyc = 3'b111; stb = 3'b111;
        @(negedge clock);
        chk("post_reset_first", gnt_a, 3'b001);

        // Round robin with all three requesting continuously.
        for (int k = 0; k < 5; k++) begin
            wait_gnt(own);
            order[k] = own;
            keep = gnt_a;
            @(negedge clock);
            tack = 1;
            @(negedge clock);
            tack = 0;
            chk("rr_locked", gnt_a, keep);
            @(negedge clock);
            cyc = ~keep; stb = ~keep;
            @(negedge clock);
            chk("rr_gap", gnt_a, 3'b000);
            cyc = 3'b111; stb = 3'b111;
            @(negedge clock);
        end
        for (int k = 0; k < 5; k++) chk("rr_order", order[k], exp_order[k]);
        cyc = 3'b000; stb = 3'b000;
        repeat (2) @(negedge clock);

        // Long silent target: saturates A's event count, B must just hold the grant.
        cyc = 3'b001; stb = 3'b001;
        @(negedge clock);
        for (int t = 0; t < 2400; t++) begin
            chk("no_wd_gnt_held", gnt_b, 3'b001);
            chk("no_wd_err", wd_err_b, 3'b000);
            @(negedge clock);
        end
        chk("wd_count_saturated", wdc_a, 8'd255);
        cyc = 3'b000; stb = 3'b000;
        repeat (2) @(negedge clock);

        // Randomized traffic; alternate between responsive and silent target.
        for (int cy = 0; cy < 3000; cy++) begin
            for (int i = 0; i < N; i++) begin
                if (cyc[i[1:0]]) begin
                    if ($urandom_range(0, 9) == 0) cyc[i[1:0]] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    cyc[i[1:0]] = 1'b1;
                end
                stb[i[1:0]] = cyc[i[1:0]] & ($urandom_range(0, 3) != 0);
            end
            if (((cy / 500) % 2) == 0) begin
                tack = ($urandom_range(0, 5) == 0);
                terr = ($urandom_range(0, 31) == 0);
            end else begin
                tack = 0;
                terr = 0;
            end
            @(negedge clock);
        end
        cyc = 3'b000; stb = 3'b000; tack = 0; terr = 0;
        repeat (3) @(negedge clock);
        chk("final_idle", gnt_a, 3'b000);

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
